// File: rtl/regfile_clr_if.sv
// Port bundle for regfile_clr: one write port, two registered read ports and
// the ready flag. The master modport is the writeback/decode side.
interface regfile_clr_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            i_enable;
    logic [AW-1:0]   i_rd_adrs;
    logic [XLEN-1:0] i_rd_data;
    logic [AW-1:0]   i_rs1_adrs;
    logic [AW-1:0]   i_rs2_adrs;
    logic            i_read_en;
    logic [XLEN-1:0] o_rs1_data;
    logic [XLEN-1:0] o_rs2_data;
    logic            o_ready;

    modport master (
        output i_enable, i_rd_adrs, i_rd_data, i_rs1_adrs, i_rs2_adrs, i_read_en,
        input  o_rs1_data, o_rs2_data, o_ready
    );

    modport slave (
        input  i_enable, i_rd_adrs, i_rd_data, i_rs1_adrs, i_rs2_adrs, i_read_en,
        output o_rs1_data, o_rs2_data, o_ready
    );
endinterface

// File: rtl/regfile_clr.sv
// Parametrised register file with post-reset clear sequencer, optional
// hardwired-zero x0, optional write-to-read bypass and read-hold for stalls.
module regfile_clr #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic          clk,
    input logic          rst,
    regfile_clr_if.slave bus
);
    localparam int NREGS = 2 ** AW;

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_clr_ptr;
    logic [XLEN-1:0] r_regs [NREGS];
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;

    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [XLEN-1:0] w_mem_data;
    logic            w_wr_accept;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_CLEAR) r_clr_ptr <= r_clr_ptr + AW'(1);
        end
    end

    // The clear sequencer owns the array write port until the last entry is zeroed.
    always_comb begin
        w_state_next = r_state;
        w_wr_accept  = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = bus.i_rd_adrs;
        w_mem_data   = bus.i_rd_data;
        case (r_state)
            S_CLEAR: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_ptr;
                w_mem_data = '0;
                if (&r_clr_ptr) w_state_next = S_RUN;
            end
            S_RUN: begin
                w_wr_accept = bus.i_enable && !(ZERO_REG && (bus.i_rd_adrs == '0));
                w_mem_we    = w_wr_accept;
            end
        endcase
    end

    // NOTE: the storage array has no reset term; it is zeroed by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_regs[w_mem_addr] <= w_mem_data;
    end

    always_comb begin
        w_rs1_val = r_regs[bus.i_rs1_adrs];
        w_rs2_val = r_regs[bus.i_rs2_adrs];
        if (BYPASS && w_wr_accept && (bus.i_rd_adrs == bus.i_rs1_adrs)) w_rs1_val = bus.i_rd_data;
        if (BYPASS && w_wr_accept && (bus.i_rd_adrs == bus.i_rs2_adrs)) w_rs2_val = bus.i_rd_data;
        if (ZERO_REG && (bus.i_rs1_adrs == '0)) w_rs1_val = '0;
        if (ZERO_REG && (bus.i_rs2_adrs == '0)) w_rs2_val = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else if (r_state == S_CLEAR) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else if (bus.i_read_en) begin
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
        end
    end

    assign bus.o_rs1_data = r_rs1_data;
    assign bus.o_rs2_data = r_rs2_data;
    assign bus.o_ready    = (r_state == S_RUN);
endmodule
